wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
Cycle sequencer for the washer datapath. Latches the selected program (wash/rinse/dry enables, water level) on start and steps through fill, agitate, drain and spin phases on a 1-second tick. Drives the valve, pump and motor enables plus remaining-time counters for the display path. Handles pause via the run button and the door interlock, then ends with a timed beep.

Parameters:
WASH_T, 6, wash agitate duration in ticks (>=1)
RINSE_T, 4, rinse agitate duration in ticks (>=1)
DRAIN_T, 2, drain duration in ticks (>=1)
SPIN_T, 3, inter-rinse spin duration in ticks (>=1)
DRY_T, 5, final spin duration in ticks (>=1)
BEEP_T, 3, done-beep duration in ticks (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle 1-second strobe
run_btn  in  1  one-cycle synchronized press pulse
door_open  in  1  level; 1 = door open
mode  in  3  {wash_en, rinse_en, dry_en}
water_lvl  in  3  water level 1..5
phase  out  4  current state code (see below)
valve_in  out  1  inlet valve on
motor_agit  out  1  agitate motor on
pump_out  out  1  drain pump on
motor_spin  out  1  spin motor on
busy  out  1  1 in any state other than IDLE
paused  out  1  sequence frozen
remain_sec  out  8  total seconds left in the program
phase_remain  out  6  seconds left in the current phase
beep  out  1  high throughout DONE

Behaviour:
- Reset (async, rst_n=0): phase=IDLE, all outputs 0, counters 0, latched config cleared.
- State codes: IDLE=0, W_FILL=1, W_AGIT=2, R_DRAIN=3, R_SPIN=4, R_FILL=5, R_AGIT=6, F_DRAIN=7, F_SPIN=8, DONE=9.
- Level L = water_lvl clamped to 1..5 (0 -> 1, >5 -> 5). Fill duration = L ticks.
- Start: in IDLE, run_btn=1 with mode!=0 and door_open=0. Latch mode and L. Load remain_sec with the sum of all enabled phase durations. Enter the first enabled phase next cycle. Any other start attempt is ignored.
- Phase order: W_FILL, W_AGIT (if wash_en); R_DRAIN, R_SPIN, R_FILL, R_AGIT (if rinse_en); F_DRAIN (always); F_SPIN (if dry_en, duration DRY_T); then DONE.
- Phase entry loads phase_remain with that phase's duration.
- Running tick (paused=0):
  - remain_sec decrements by 1.
  - If phase_remain==1: advance to the next phase in the same cycle and load its duration.
  - Otherwise phase_remain decrements by 1.
- Actuator outputs are registered and decoded from the next state, so they are valid in the same cycle phase changes:
  - valve_in in W_FILL/R_FILL.
  - motor_agit in W_AGIT/R_AGIT.
  - pump_out in *_DRAIN and *_SPIN.
  - motor_spin in R_SPIN/F_SPIN.
  - All actuators forced 0 while paused, in IDLE and in DONE.
- Pause:
  - Entry: run_btn while running and not paused sets paused=1. door_open=1 while running also sets paused=1.
  - Release: run_btn while paused clears paused only if door_open=0; otherwise it is ignored.
  - The door closing never auto-resumes.
  - Ticks are ignored while paused; counters hold.
- Simultaneous events: run_btn (or door_open rising) in the same cycle as tick -> the pause wins and the tick is not consumed. Resume in the same cycle as tick -> the tick is not consumed.
- DONE: beep=1, busy=1, remain_sec=0. phase_remain loaded with BEEP_T and counts down on ticks. At 1 -> IDLE, beep=0. run_btn and door_open are ignored in DONE.
- Config inputs are ignored after start; changes take effect only on the next start.
- rst_n assertion mid-program aborts immediately to the reset state.

Test Plan:
- mode=111, L=2, no pauses -> phases 1,2,3,4,5,6,7,8,9; remain_sec=26 after start, reaching 0 on entry to DONE; beep high for 3 ticks; then IDLE, busy=0.
- mode=100, water_lvl=7 (clamped to 5) -> remain_sec=13; valve_in for 5 ticks, motor_agit for 6, pump_out for 2; motor_spin never asserted.
- mode=001 -> F_DRAIN (2 ticks, pump_out only) then F_SPIN (5 ticks, pump_out and motor_spin); remain_sec starts at 7.
- mode=111, L=1: during W_AGIT with phase_remain=4, door_open=1 -> paused=1, actuators 0, counters hold across 10 ticks. run_btn while the door is open is ignored. Close the door, press run_btn -> resumes with phase_remain=4.
- run_btn and tick in the same cycle mid-W_AGIT -> paused=1 and phase_remain unchanged. mode=000 or door_open=1 at run_btn in IDLE -> stays IDLE.
- rst_n low during R_SPIN -> phase=0 and all outputs 0 asynchronously, before the next clk edge. A later start runs a full program normally.

Source files
------------

// File: rtl/wash_if.sv
// Washer sequencer I/O bundle: operator/config inputs and
// phase/actuator/display outputs.
interface wash_if;
  logic       tick;
  logic       run_btn;
  logic       door_open;
  logic [2:0] mode;
  logic [2:0] water_lvl;
  logic [3:0] phase;
  logic       valve_in;
  logic       motor_agit;
  logic       pump_out;
  logic       motor_spin;
  logic       busy;
  logic       paused;
  logic [7:0] remain_sec;
  logic [5:0] phase_remain;
  logic       beep;

  modport master (
    output tick, run_btn, door_open, mode, water_lvl,
    input  phase, valve_in, motor_agit, pump_out, motor_spin,
    input  busy, paused, remain_sec, phase_remain, beep
  );

  modport slave (
    input  tick, run_btn, door_open, mode, water_lvl,
    output phase, valve_in, motor_agit, pump_out, motor_spin,
    output busy, paused, remain_sec, phase_remain, beep
  );
endinterface

// File: rtl/wash_sequencer.sv
// Washer cycle sequencer: fill/agitate/drain/spin phases on a
// 1 s tick, with run-button/door pause and a timed done beep.
module wash_sequencer #(
  parameter int unsigned WASH_T  = 6,
  parameter int unsigned RINSE_T = 4,
  parameter int unsigned DRAIN_T = 2,
  parameter int unsigned SPIN_T  = 3,
  parameter int unsigned DRY_T   = 5,
  parameter int unsigned BEEP_T  = 3
) (
  input logic clk,
  input logic rst_n,
  wash_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    W_FILL  = 4'd1,
    W_AGIT  = 4'd2,
    R_DRAIN = 4'd3,
    R_SPIN  = 4'd4,
    R_FILL  = 4'd5,
    R_AGIT  = 4'd6,
    F_DRAIN = 4'd7,
    F_SPIN  = 4'd8,
    DONE    = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic       paused_q, paused_d;
  logic [2:0] mode_q, mode_d;
  logic [2:0] lvl_q, lvl_d;
  logic [2:0] lvl_in;
  logic [7:0] rem_q, rem_d;
  logic [5:0] pr_q, pr_d;
  logic [3:0] act_q, act_d;

  function automatic state_t first_phase(input logic [2:0] m);
    if (m[2])      return W_FILL;
    else if (m[1]) return R_DRAIN;
    else           return F_DRAIN;
  endfunction

  function automatic state_t next_phase(input state_t s,
                                        input logic [2:0] m);
    state_t n;
    n = DONE;
    case (s)
      W_FILL:  n = W_AGIT;
      W_AGIT:  n = m[1] ? R_DRAIN : F_DRAIN;
      R_DRAIN: n = R_SPIN;
      R_SPIN:  n = R_FILL;
      R_FILL:  n = R_AGIT;
      R_AGIT:  n = F_DRAIN;
      F_DRAIN: n = m[0] ? F_SPIN : DONE;
      default: n = DONE;
    endcase
    return n;
  endfunction

  function automatic logic [5:0] dur(input state_t s,
                                     input logic [2:0] l);
    logic [5:0] d;
    d = '0;
    case (s)
      W_FILL, R_FILL:   d = {3'b000, l};
      W_AGIT:           d = 6'(WASH_T);
      R_AGIT:           d = 6'(RINSE_T);
      R_DRAIN, F_DRAIN: d = 6'(DRAIN_T);
      R_SPIN:           d = 6'(SPIN_T);
      F_SPIN:           d = 6'(DRY_T);
      DONE:             d = 6'(BEEP_T);
      default:          d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] total(input logic [2:0] m,
                                       input logic [2:0] l);
    logic [7:0] t;
    t = 8'(DRAIN_T);
    if (m[2]) t = t + {5'b0, l} + 8'(WASH_T);
    if (m[1]) t = t + 8'(DRAIN_T) + 8'(SPIN_T)
                + {5'b0, l} + 8'(RINSE_T);
    if (m[0]) t = t + 8'(DRY_T);
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      paused_q <= 1'b0;
      mode_q   <= '0;
      lvl_q    <= '0;
      rem_q    <= '0;
      pr_q     <= '0;
      act_q    <= '0;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
      mode_q   <= mode_d;
      lvl_q    <= lvl_d;
      rem_q    <= rem_d;
      pr_q     <= pr_d;
      act_q    <= act_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    mode_d   = mode_q;
    lvl_d    = lvl_q;
    rem_d    = rem_q;
    pr_d     = pr_q;
    act_d    = '0;
    if (bus.water_lvl == 3'd0)     lvl_in = 3'd1;
    else if (bus.water_lvl > 3'd5) lvl_in = 3'd5;
    else                           lvl_in = bus.water_lvl;

    case (state_q)
      IDLE: begin
        if (bus.run_btn && bus.mode != 3'b000
            && !bus.door_open) begin
          mode_d  = bus.mode;
          lvl_d   = lvl_in;
          rem_d   = total(bus.mode, lvl_in);
          state_d = first_phase(bus.mode);
          pr_d    = dur(state_d, lvl_in);
        end
      end
      DONE: begin
        if (bus.tick) begin
          if (pr_q == 6'd1) begin
            state_d = IDLE;
            pr_d    = '0;
            mode_d  = '0;
            lvl_d   = '0;
          end else begin
            pr_d = pr_q - 6'd1;
          end
        end
      end
      default: begin
        // pause/resume events take priority and swallow a coincident tick
        if (!paused_q) begin
          if (bus.run_btn || bus.door_open) begin
            paused_d = 1'b1;
          end else if (bus.tick) begin
            rem_d = rem_q - 8'd1;
            if (pr_q == 6'd1) begin
              state_d = next_phase(state_q, mode_q);
              pr_d    = dur(state_d, lvl_q);
              if (state_d == DONE) rem_d = '0;
            end else begin
              pr_d = pr_q - 6'd1;
            end
          end
        end else if (bus.run_btn && !bus.door_open) begin
          paused_d = 1'b0;
        end
      end
    endcase

    // {valve_in, motor_agit, pump_out, motor_spin}
    if (!paused_d) begin
      unique case (1'b1)
        (state_d == W_FILL || state_d == R_FILL):
          act_d = 4'b1000;
        (state_d == W_AGIT || state_d == R_AGIT):
          act_d = 4'b0100;
        (state_d == R_DRAIN || state_d == F_DRAIN):
          act_d = 4'b0010;
        (state_d == R_SPIN || state_d == F_SPIN):
          act_d = 4'b0011;
        default:
          act_d = 4'b0000;
      endcase
    end
  end

  assign bus.phase        = state_q;
  assign bus.valve_in     = act_q[3];
  assign bus.motor_agit   = act_q[2];
  assign bus.pump_out     = act_q[1];
  assign bus.motor_spin   = act_q[0];
  assign bus.busy         = (state_q != IDLE);
  assign bus.paused       = paused_q;
  assign bus.remain_sec   = rem_q;
  assign bus.phase_remain = pr_q;
  assign bus.beep         = (state_q == DONE);

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: start-vector table,
// full-program scoreboard runs, pause and async-reset corners.
module tb_wash_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wash_if u_if();

  wash_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [2:0] lvl;
    logic       door;
    logic [3:0] ph;
    logic [7:0] rem;
    logic [5:0] pr;
    logic [3:0] act;
  } vec_t;

  typedef struct {
    logic [3:0] ph;
    int         dur;
    logic [3:0] act;
  } seg_t;

  vec_t vecs[9];
  vec_t exp_q[$];

  function automatic logic [3:0] acts();
    return {u_if.valve_in, u_if.motor_agit,
            u_if.pump_out, u_if.motor_spin};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    u_if.tick = 1'b1;
    step();
    u_if.tick = 1'b0;
  endtask

  task automatic press();
    u_if.run_btn = 1'b1;
    step();
    u_if.run_btn = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_prog(input logic [2:0] m, input logic [2:0] wl);
    seg_t q[$];
    seg_t s;
    int   l;
    int   tot;
    int   exp_rem;
    l = (wl == 0) ? 1 : ((wl > 5) ? 5 : int'(wl));
    if (m[2]) begin
      q.push_back('{4'd1, l, 4'b1000});
      q.push_back('{4'd2, 6, 4'b0100});
    end
    if (m[1]) begin
      q.push_back('{4'd3, 2, 4'b0010});
      q.push_back('{4'd4, 3, 4'b0011});
      q.push_back('{4'd5, l, 4'b1000});
      q.push_back('{4'd6, 4, 4'b0100});
    end
    q.push_back('{4'd7, 2, 4'b0010});
    if (m[0]) q.push_back('{4'd8, 5, 4'b0011});
    q.push_back('{4'd9, 3, 4'b0000});
    tot = 0;
    foreach (q[i]) if (q[i].ph != 4'd9) tot += q[i].dur;

    u_if.mode      = m;
    u_if.water_lvl = wl;
    press();
    chk("start_remain", u_if.remain_sec, tot);
    exp_rem = tot;
    while (q.size() > 0) begin
      s = q.pop_front();
      chk("seg_phase", u_if.phase, s.ph);
      chk("seg_pr", u_if.phase_remain, s.dur);
      chk("seg_act", acts(), s.act);
      chk("seg_busy", u_if.busy, 1);
      chk("seg_beep", u_if.beep, (s.ph == 4'd9) ? 1 : 0);
      if (s.ph == 4'd9) begin
        u_if.door_open = 1'b1;
        u_if.run_btn   = 1'b1;
        step();
        u_if.run_btn   = 1'b0;
        u_if.door_open = 1'b0;
        chk("done_ignore_phase", u_if.phase, 9);
        chk("done_ignore_pause", u_if.paused, 0);
      end
      for (int i = 1; i <= s.dur; i++) begin
        step();
        pulse_tick();
        if (s.ph != 4'd9) exp_rem--;
        chk("tick_remain", u_if.remain_sec, exp_rem);
        if (i < s.dur)
          chk("tick_pr", u_if.phase_remain, s.dur - i);
      end
    end
    chk("end_phase", u_if.phase, 0);
    chk("end_busy", u_if.busy, 0);
    chk("end_beep", u_if.beep, 0);
  endtask

  initial begin
    vec_t e;
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    u_if.tick      = 1'b0;
    u_if.run_btn   = 1'b0;
    u_if.door_open = 1'b0;
    u_if.mode      = 3'b000;
    u_if.water_lvl = 3'd1;

    vecs[0] = '{3'b000, 3'd2, 1'b0, 4'd0,  8'd0, 6'd0, 4'b0000};
    vecs[1] = '{3'b111, 3'd2, 1'b1, 4'd0,  8'd0, 6'd0, 4'b0000};
    vecs[2] = '{3'b100, 3'd0, 1'b0, 4'd1,  8'd9, 6'd1, 4'b1000};
    vecs[3] = '{3'b100, 3'd7, 1'b0, 4'd1, 8'd13, 6'd5, 4'b1000};
    vecs[4] = '{3'b010, 3'd3, 1'b0, 4'd3, 8'd14, 6'd2, 4'b0010};
    vecs[5] = '{3'b001, 3'd1, 1'b0, 4'd7,  8'd7, 6'd2, 4'b0010};
    vecs[6] = '{3'b011, 3'd2, 1'b0, 4'd3, 8'd18, 6'd2, 4'b0010};
    vecs[7] = '{3'b101, 3'd4, 1'b0, 4'd1, 8'd17, 6'd4, 4'b1000};
    vecs[8] = '{3'b110, 3'd6, 1'b0, 4'd1, 8'd27, 6'd5, 4'b1000};

    #12;
    chk("rst_phase", u_if.phase, 0);
    chk("rst_act", acts(), 0);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_remain", u_if.remain_sec, 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      do_reset();
      u_if.door_open = vecs[i].door;
      u_if.mode      = vecs[i].mode;
      u_if.water_lvl = vecs[i].lvl;
      u_if.run_btn   = 1'b1;
      exp_q.push_back(vecs[i]);
      step();
      u_if.run_btn   = 1'b0;
      u_if.door_open = 1'b0;
      e = exp_q.pop_front();
      chk("vec_phase", u_if.phase, e.ph);
      chk("vec_remain", u_if.remain_sec, e.rem);
      chk("vec_pr", u_if.phase_remain, e.pr);
      chk("vec_act", acts(), e.act);
      chk("vec_busy", u_if.busy, (e.ph != 0) ? 1 : 0);
    end

    do_reset();
    run_prog(3'b111, 3'd2);
    run_prog(3'b100, 3'd7);
    run_prog(3'b001, 3'd4);

    // pause via door, ignored resume, manual resume
    u_if.mode      = 3'b111;
    u_if.water_lvl = 3'd1;
    press();
    chk("p_start_rem", u_if.remain_sec, 24);
    pulse_tick();
    pulse_tick();
    pulse_tick();
    chk("p_phase", u_if.phase, 2);
    chk("p_pr4", u_if.phase_remain, 4);
    u_if.door_open = 1'b1;
    step();
    chk("p_door_paused", u_if.paused, 1);
    chk("p_door_act", acts(), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      pulse_tick();
    end
    chk("p_hold_pr", u_if.phase_remain, 4);
    chk("p_hold_rem", u_if.remain_sec, 21);
    chk("p_hold_phase", u_if.phase, 2);
    press();
    chk("p_btn_door_open", u_if.paused, 1);
    u_if.door_open = 1'b0;
    step();
    step();
    chk("p_no_autoresume", u_if.paused, 1);
    press();
    chk("p_resumed", u_if.paused, 0);
    chk("p_resume_pr", u_if.phase_remain, 4);
    chk("p_resume_act", acts(), 4'b0100);

    // button and tick together: pause wins, then resume swallows tick
    u_if.run_btn = 1'b1;
    u_if.tick    = 1'b1;
    step();
    chk("s_pause", u_if.paused, 1);
    chk("s_pause_pr", u_if.phase_remain, 4);
    chk("s_pause_rem", u_if.remain_sec, 21);
    step();
    u_if.run_btn = 1'b0;
    u_if.tick    = 1'b0;
    chk("s_resume", u_if.paused, 0);
    chk("s_resume_pr", u_if.phase_remain, 4);
    pulse_tick();
    chk("s_tick_pr", u_if.phase_remain, 3);
    chk("s_tick_rem", u_if.remain_sec, 20);
    for (int i = 0; i < 5; i++) pulse_tick();
    chk("r_spin_phase", u_if.phase, 4);
    chk("r_spin_act", acts(), 4'b0011);

    // asynchronous abort mid-phase
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_phase", u_if.phase, 0);
    chk("a_act", acts(), 0);
    chk("a_busy", u_if.busy, 0);
    chk("a_paused", u_if.paused, 0);
    chk("a_rem", u_if.remain_sec, 0);
    chk("a_pr", u_if.phase_remain, 0);
    rst_n = 1'b1;
    step();
    run_prog(3'b111, 3'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
